// File: rtl/vec_alu_pipe.sv
// Pipelined binary16 vector ALU: VADD, SMUL (scalar broadcast), optional VDOT reduction.
// Define VALU_DOT_EN to build the VDOT state; without it opcode 4'b0001 is illegal.
//
// state | meaning
// IDLE  | empty, ready for a request
// DOT   | accumulating one lane product per cycle
// HOLD  | result valid, waiting for the consumer
module vec_alu_pipe #(
  parameter int LANES = 16,
  parameter int VW    = LANES * 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    opcode,
  input  logic [VW-1:0] op_1,
  input  logic [VW-1:0] op_2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [VW-1:0] result,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, DOT, HOLD} state_t;

  localparam logic [3:0] OP_VADD = 4'b0000;
  localparam logic [3:0] OP_SMUL = 4'b0010;

  state_t state;

  // Rounds m * 2^e to binary16, round-to-nearest-even, with gradual underflow.
  function automatic logic [15:0] pack(input logic s, input int e, input logic [47:0] m);
    int          msb, k, sh;
    logic [47:0] n;
    logic        g, st;
    if (m == 48'd0) return {s, 15'd0};
    msb = 0;
    for (int i = 0; i < 48; i++) if (m[i]) msb = i;
    k = msb + e - 10;
    if (k < -24) k = -24;
    sh = k - e;
    if (sh > 0) begin
      n  = m >> sh;
      g  = m[sh-1];
      st = |(m & ((48'd1 << (sh - 1)) - 48'd1));
      if (g && (st || n[0])) n = n + 48'd1;
    end else begin
      n = m << (-sh);
    end
    if (n == 48'd2048) begin
      n = 48'd1024;
      k = k + 1;
    end
    if (n < 48'd1024) return {s, 5'd0, n[9:0]};
    if (k + 25 >= 31) return {s, 5'h1F, 10'd0};
    return {s, 5'(k + 25), n[9:0]};
  endfunction

  function automatic logic [15:0] float_add(input logic [15:0] a, input logic [15:0] b);
    logic [4:0]  ea, eb, emin;
    logic [47:0] ma, mb, m;
    logic        s;
    ea = a[14:10];
    eb = b[14:10];
    if ((ea == 5'h1F && a[9:0] != 10'd0) || (eb == 5'h1F && b[9:0] != 10'd0)) return 16'h7E00;
    if (ea == 5'h1F && eb == 5'h1F) return (a[15] == b[15]) ? a : 16'h7E00;
    if (ea == 5'h1F) return a;
    if (eb == 5'h1F) return b;
    ma = {37'd0, ea != 5'd0, a[9:0]};
    mb = {37'd0, eb != 5'd0, b[9:0]};
    if (ea == 5'd0) ea = 5'd1;
    if (eb == 5'd0) eb = 5'd1;
    emin = (ea < eb) ? ea : eb;
    // Align onto the smaller exponent: exact in 48 bits, so one rounding step suffices.
    ma = ma << (ea - emin);
    mb = mb << (eb - emin);
    if (a[15] == b[15]) begin
      m = ma + mb;
      s = a[15];
    end else if (ma >= mb) begin
      m = ma - mb;
      s = (m == 48'd0) ? 1'b0 : a[15];
    end else begin
      m = mb - ma;
      s = b[15];
    end
    return pack(s, int'(emin) - 25, m);
  endfunction

  function automatic logic [15:0] float_mul(input logic [15:0] a, input logic [15:0] b);
    logic [4:0]  ea, eb;
    logic [10:0] ma, mb;
    logic [21:0] p;
    logic        s, a_inf, b_inf, a_zero, b_zero;
    ea     = a[14:10];
    eb     = b[14:10];
    s      = a[15] ^ b[15];
    a_inf  = (ea == 5'h1F) && (a[9:0] == 10'd0);
    b_inf  = (eb == 5'h1F) && (b[9:0] == 10'd0);
    a_zero = (a[14:0] == 15'd0);
    b_zero = (b[14:0] == 15'd0);
    if ((ea == 5'h1F && !a_inf) || (eb == 5'h1F && !b_inf)) return 16'h7E00;
    if ((a_inf && b_zero) || (b_inf && a_zero)) return 16'h7E00;
    if (a_inf || b_inf) return {s, 5'h1F, 10'd0};
    ma = {ea != 5'd0, a[9:0]};
    mb = {eb != 5'd0, b[9:0]};
    if (ea == 5'd0) ea = 5'd1;
    if (eb == 5'd0) eb = 5'd1;
    p = ma * mb;
    return pack(s, int'(ea) + int'(eb) - 50, {26'd0, p});
  endfunction

  logic [VW-1:0] imm_res;
  logic          imm_err;

  always_comb begin
    imm_res = '0;
    imm_err = 1'b0;
    case (opcode)
      OP_VADD: for (int i = 0; i < LANES; i++)
                 imm_res[16*i +: 16] = float_add(op_1[16*i +: 16], op_2[16*i +: 16]);
      OP_SMUL: for (int i = 0; i < LANES; i++)
                 imm_res[16*i +: 16] = float_mul(op_1[16*i +: 16], op_2[15:0]);
      default: imm_err = 1'b1;
    endcase
  end

`ifdef VALU_DOT_EN
  localparam logic [3:0] OP_VDOT = 4'b0001;
  localparam int         IW      = $clog2(LANES);
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);

  logic [VW-1:0] op_a_q, op_b_q;
  logic [15:0]   acc, dot_next;
  logic [IW-1:0] idx;

  always_comb begin
    dot_next = float_add(acc, float_mul(op_a_q[16*idx +: 16], op_b_q[16*idx +: 16]));
  end
`endif

  assign in_ready = (state == IDLE) || (state == HOLD && out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      err       <= 1'b0;
      result    <= '0;
`ifdef VALU_DOT_EN
      acc       <= 16'h0000;
      idx       <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
`endif
    end else begin
      if (in_valid && in_ready) begin
`ifdef VALU_DOT_EN
        if (opcode == OP_VDOT) begin
          state     <= DOT;
          out_valid <= 1'b0;
          acc       <= 16'h0000;
          idx       <= '0;
          op_a_q    <= op_1;
          op_b_q    <= op_2;
        end else
`endif
        begin
          state     <= HOLD;
          out_valid <= 1'b1;
          result    <= imm_res;
          err       <= imm_err;
        end
      end else if (state == HOLD && out_ready) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end
`ifdef VALU_DOT_EN
      else if (state == DOT) begin
        acc <= dot_next;
        if (idx == LAST) begin
          state     <= HOLD;
          out_valid <= 1'b1;
          err       <= 1'b0;
          result    <= {{(VW-16){1'b0}}, dot_next};
        end else begin
          idx <= idx + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_vec_alu_pipe.sv
// Scoreboard bench for vec_alu_pipe; reference arithmetic done in real numbers, rounded to binary16.
module tb_vec_alu_pipe;
  localparam int LANES = 4;
  localparam int VW    = LANES * 16;

  logic          clk, rst, in_valid, in_ready, out_valid, out_ready, err;
  logic [3:0]    opcode;
  logic [VW-1:0] op_1, op_2, result;

  vec_alu_pipe #(.LANES(LANES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .op_1(op_1), .op_2(op_2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic rand_bp = 1'b0;
  logic [VW:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // ---- reference model ----
  function automatic real p2(input int e);
    real r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else repeat (-e) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real v;
    if (h[14:10] == 5'd0) v = real'(h[9:0]) * p2(-24);
    else v = real'(1024 + int'(h[9:0])) * p2(int'(h[14:10]) - 25);
    return h[15] ? -v : v;
  endfunction

  function automatic longint rne(input real q);
    real    f  = $floor(q);
    longint n  = longint'(f);
    real    fr = q - f;
    if (fr > 0.5 || (fr == 0.5 && n[0])) n++;
    return n;
  endfunction

  function automatic logic [15:0] r2h(input real x);
    logic [63:0] bits = $realtobits(x);
    logic        s    = bits[63];
    real         a    = s ? -x : x;
    longint      n;
    int          e;
    if (a >= 65520.0) return {s, 15'h7C00};
    if (a < p2(-14)) begin
      n = rne(a * p2(24));
      return {s, 15'(n)};
    end
    e = -14;
    while (a >= p2(e + 1)) e++;
    n = rne(a * p2(10 - e));
    if (n == 2048) begin
      n = 1024;
      e++;
    end
    return {s, 5'(e + 15), 10'(n - 1024)};
  endfunction

  function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
    return r2h(h2r(a) + h2r(b));
  endfunction

  function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
    return r2h(h2r(a) * h2r(b));
  endfunction

  function automatic logic [VW:0] model(input logic [3:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r = '0;
    logic [15:0]   acc;
    case (op)
      4'h0: for (int i = 0; i < LANES; i++) r[16*i +: 16] = m_add(a[16*i +: 16], b[16*i +: 16]);
      4'h2: for (int i = 0; i < LANES; i++) r[16*i +: 16] = m_mul(a[16*i +: 16], b[15:0]);
`ifdef VALU_DOT_EN
      4'h1: begin
        acc = 16'h0000;
        for (int i = 0; i < LANES; i++) acc = m_add(acc, m_mul(a[16*i +: 16], b[16*i +: 16]));
        r[15:0] = acc;
      end
`endif
      default: return {1'b1, {VW{1'b0}}};
    endcase
    return {1'b0, r};
  endfunction

  function automatic logic [VW-1:0] bcast(input logic [15:0] h);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[16*i +: 16] = h;
    return v;
  endfunction

  function automatic logic [15:0] rh();
    return {1'($urandom_range(0, 1)), 5'($urandom_range(0, 20)), 10'($urandom)};
  endfunction

  function automatic logic [VW-1:0] rvec();
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[16*i +: 16] = rh();
    return v;
  endfunction

  // ---- driver: called #1 after a rising edge, returns #1 after the accepting edge ----
  task automatic issue(input logic [3:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b);
    int n = 0;
    in_valid = 1'b1;
    opcode   = op;
    op_1     = a;
    op_2     = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 128'(n), 128'(0));
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((out_valid || exp_q.size() != 0) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", 128'(exp_q.size()), 128'(0));
  endtask

  // ---- monitor ----
  initial begin
    logic [VW:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", 128'({err, result}), 128'(0));
        end else begin
          e = exp_q.pop_front();
          chk("sb_result", 128'({err, result}), 128'(e));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---- directed and random stimulus ----
  initial begin
    logic [VW-1:0] a, b, hold_exp;
    logic [VW:0]   tmp;
    int            n, c0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; opcode = 4'h0; op_1 = '0; op_2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_err_result", 128'({err, result}), 128'(0));
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 128'(in_ready), 128'(1));
    chk("rel_out_valid", 128'(out_valid), 128'(0));

    // VADD 1+1, latency 1
    issue(4'h0, bcast(16'h3C00), bcast(16'h3C00));
    chk("vadd_lat1", 128'(out_valid), 128'(1));
    chk("vadd_two", 128'(result), 128'(bcast(16'h4000)));
    wait_drain();

    // cancellation and output hold under backpressure
    a = '0; a[15:0] = 16'hC680;
    b = '0; b[15:0] = 16'h4680;
    tmp = model(4'h0, a, b);
    hold_exp = tmp[VW-1:0];
    out_ready = 1'b0;
    issue(4'h0, a, b);
    repeat (5) begin
      @(negedge clk);
      chk("hold_result", 128'(result), 128'(hold_exp));
      chk("hold_in_ready", 128'(in_ready), 128'(0));
      chk("hold_out_valid", 128'(out_valid), 128'(1));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_after_xfer", 128'(out_valid), 128'(0));

    // SMUL broadcast ignores B lanes above 0
    b = bcast(16'h7C00);
    b[15:0] = 16'h4000;
    issue(4'h2, bcast(16'h3C00), b);
    wait_drain();

    // VDOT latency and in_ready low while accumulating
    issue(4'h1, bcast(16'h3C00), bcast(16'h4000));
    n = 1;
    while (!out_valid && n < 40) begin
      chk("dot_in_ready", 128'(in_ready), 128'(0));
      @(posedge clk);
      #1;
      n++;
    end
`ifdef VALU_DOT_EN
    chk("vdot_latency", 128'(n), 128'(LANES + 1));
`else
    chk("vdot_latency", 128'(n), 128'(1));
`endif
    wait_drain();

    // illegal opcode, then a VADD accepted in the same cycle the error result leaves
    issue(4'hF, rvec(), rvec());
    chk("illegal_err", 128'(err), 128'(1));
    issue(4'h0, rvec(), rvec());
    chk("b2b_valid", 128'(out_valid), 128'(1));
    chk("b2b_err", 128'(err), 128'(0));
    wait_drain();

    // throughput: back-to-back VADD/SMUL, one per cycle
    c0 = cyc;
    for (int i = 0; i < 8; i++) issue((i % 2 == 0) ? 4'h0 : 4'h2, rvec(), rvec());
    chk("throughput", 128'(cyc - c0), 128'(8));
    wait_drain();

    // reset two cycles into a VDOT
    issue(4'h1, rvec(), rvec());
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_result", 128'({err, result}), 128'(0));
    exp_q.delete();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    issue(4'h0, bcast(16'h3C00), bcast(16'h3C00));
    wait_drain();
    issue(4'h1, bcast(16'h4000), bcast(16'h4000));
    wait_drain();

    // randomized mix with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 150; i++) begin
      n = $urandom_range(0, 9);
      if (n < 4)      issue(4'h0, rvec(), rvec());
      else if (n < 6) issue(4'h2, rvec(), rvec());
      else if (n < 8) issue(4'h1, rvec(), rvec());
      else            issue(4'($urandom_range(3, 15)), rvec(), rvec());
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain();
    chk("final_idle", 128'(out_valid), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
